// File: rtl/axi_read_mem_pkg.sv
// Shared AXI read-channel types, bus widths and a beat-size helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_read_mem_pkg;

    localparam int AXI_ADDR_WIDTH     = 32;
    localparam int AXI_DATA_WIDTH     = 32;
    localparam int AXI_BYTES_PER_WORD = AXI_DATA_WIDTH / 8;
    localparam int AXI_WORD_SHIFT     = $clog2(AXI_BYTES_PER_WORD);

    typedef enum logic [2:0] {
        AXI_SIZE_1B   = 3'd0,
        AXI_SIZE_2B   = 3'd1,
        AXI_SIZE_4B   = 3'd2,
        AXI_SIZE_8B   = 3'd3,
        AXI_SIZE_16B  = 3'd4,
        AXI_SIZE_32B  = 3'd5,
        AXI_SIZE_64B  = 3'd6,
        AXI_SIZE_128B = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_type_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    // Number of bytes moved by one beat of the given size.
    function automatic logic [AXI_ADDR_WIDTH-1:0] axi_beat_bytes(input axi_size_t size);
        return AXI_ADDR_WIDTH'(1) << size;
    endfunction

endpackage

// File: rtl/axi_read_mem_if.sv
// AXI4 read address (AR) and read data (R) channels between a master and a slave.
// Latency: none (wires only).
// Backpressure: valid/ready on both channels, driven by the endpoints.
interface axi_read_if;
    import axi_read_mem_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    axi_size_t                 arsize;
    axi_burst_type_t           arburst;
    logic                      arvalid;
    logic                      arready;

    logic [AXI_DATA_WIDTH-1:0] rdata;
    axi_resp_t                 rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_read_mem_addr_gen.sv
// Next-beat address and burst legality for FIXED/INCR/WRAP AXI bursts.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take next_addr.
module axi_burst_addr_gen
    import axi_read_mem_pkg::*;
(
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [7:0]                len,
    input  axi_size_t                 size,
    input  axi_burst_type_t           burst,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr,
    output logic                      burst_err
);

    logic [AXI_ADDR_WIDTH-1:0] incr;
    logic [AXI_ADDR_WIDTH-1:0] incr_addr;
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;

    // Address step per burst type, plus flagging of bursts this slave cannot serve.
    always_comb begin
        incr      = axi_beat_bytes(size);
        incr_addr = addr + incr;
        // Wrap window is (len+1) beats; legal WRAP lengths make this a power of two.
        wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) * incr) - AXI_ADDR_WIDTH'(1);
        next_addr = addr;
        burst_err = 1'b0;
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_INCR:  next_addr = incr_addr;
            AXI_BURST_WRAP: begin
                next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                burst_err = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
            end
            default:         burst_err = 1'b1;
        endcase
        // A beat wider than the data bus cannot be returned.
        if (int'(size) > AXI_WORD_SHIFT) begin
            burst_err = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_mem.sv
// AXI4 read-only memory slave serving FIXED/INCR/WRAP bursts from a word array.
// Latency: first rvalid LATENCY cycles after AR acceptance, then one beat per cycle.
// Backpressure: R beat held stable while rready=0; arready low for the whole burst.
module axi_read_mem
    import axi_read_mem_pkg::*;
#(
    parameter int    MEM_DEPTH = 4096,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axi_read_if.slave                    axi,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] bd_waddr,
    input  logic [AXI_DATA_WIDTH-1:0]    bd_wdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_WAIT  = 2'd1,
        MEM_BURST = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    axi_size_t                 size_q;
    axi_burst_type_t           burst_q;
    logic [7:0]                beat_cnt;
    logic [15:0]               wait_cnt;

    logic [AXI_ADDR_WIDTH-1:0] next_addr;
    logic                      burst_err;
    logic                      addr_oor;
    logic                      beat_err;
    logic [IDX_W-1:0]          word_idx;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Backdoor loader port; the array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_waddr] <= bd_wdata;
        end
    end

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .burst_err (burst_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and channel handshake outputs.
    always_comb begin
        state_d     = state_q;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid) begin
                    state_d = (LATENCY > 0) ? MEM_WAIT : MEM_BURST;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt == 16'(LATENCY - 1)) begin
                    state_d = MEM_BURST;
                end
            end
            MEM_BURST: begin
                axi.rvalid = 1'b1;
                if (axi.rready && axi.rlast) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // Burst context: captured on AR acceptance, stepped on each R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= AXI_SIZE_1B;
            burst_q  <= AXI_BURST_FIXED;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (axi.arvalid) begin
                        addr_q   <= axi.araddr;
                        len_q    <= axi.arlen;
                        size_q   <= axi.arsize;
                        burst_q  <= axi.arburst;
                        beat_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                MEM_BURST: begin
                    if (axi.rready) begin
                        addr_q   <= next_addr;
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign word_idx = addr_q[AXI_WORD_SHIFT +: IDX_W];
    assign addr_oor = (addr_q >> (AXI_WORD_SHIFT + IDX_W)) != '0;
    assign beat_err = burst_err || addr_oor;

    // R payload: combinational array read at the registered beat address, zeroed on error.
    always_comb begin
        axi.rdata = '0;
        axi.rresp = AXI_RESP_OKAY;
        axi.rlast = 1'b0;
        if (state_q == MEM_BURST) begin
            axi.rlast = (beat_cnt == len_q);
            if (beat_err) begin
                axi.rresp = AXI_RESP_SLVERR;
            end else begin
                axi.rdata = mem[word_idx];
            end
        end
    end

endmodule

// File: tb/tb_axi_read_mem.sv
// Directed bench for axi_read_mem: burst table plus backpressure, reset and zero-latency sequences.
// Latency: checks first-beat timing against LATENCY for both builds.
// Backpressure: exercises rready stalls and verifies beat stability.
module tb_axi_read_mem;
    import axi_read_mem_pkg::*;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SE = 2'b10;

    logic        clk;
    logic        rst_n;
    logic        bd_we;
    logic [11:0] bd_waddr;
    logic [31:0] bd_wdata;

    int checks   = 0;
    int failures = 0;

    axi_read_if axi0 ();
    axi_read_if axi1 ();

    axi_read_mem #(.MEM_DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (axi0),
        .bd_we    (bd_we),
        .bd_waddr (bd_waddr),
        .bd_wdata (bd_wdata)
    );

    axi_read_mem #(.MEM_DEPTH(DEPTH), .LATENCY(0), .INIT_FILE("")) u_dut_lat0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (axi1),
        .bd_we    (bd_we),
        .bd_waddr (bd_waddr),
        .bd_wdata (bd_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  rs;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.addr  = addr;
        v.len   = len;
        v.size  = size;
        v.burst = burst;
        v.d     = {d3, d2, d1, d0};
        v.rs    = {r3, r2, r1, r0};
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d] actual=%h required=%h", name, tag, act, exp);
        end
    endtask

    // Issue one AR on the LATENCY=2 instance and check every R beat with rready held high.
    task automatic do_burst(input int tag, input vec_t v);
        int lat;
        axi0.rready = 1'b1;
        check("arready_idle", tag, 32'(axi0.arready), 32'd1);
        axi0.araddr  = v.addr;
        axi0.arlen   = v.len;
        axi0.arsize  = axi_size_t'(v.size);
        axi0.arburst = axi_burst_type_t'(v.burst);
        axi0.arvalid = 1'b1;
        @(posedge clk);
        #1;
        axi0.arvalid = 1'b0;
        check("arready_busy", tag, 32'(axi0.arready), 32'd0);
        @(negedge clk);
        lat = 0;
        while (!axi0.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", tag, 32'(lat), 32'(LAT));
        for (int b = 0; b <= int'(v.len); b++) begin
            check("rvalid", tag, 32'(axi0.rvalid), 32'd1);
            check("rdata", tag, axi0.rdata, v.d[b]);
            check("rresp", tag, 32'(axi0.rresp), 32'(v.rs[b]));
            check("rlast", tag, 32'(axi0.rlast), 32'(b == int'(v.len)));
            @(negedge clk);
        end
        check("rvalid_end", tag, 32'(axi0.rvalid), 32'd0);
        check("arready_end", tag, 32'(axi0.arready), 32'd1);
    endtask

    initial begin
        logic [6:0] pat;
        int         hs;
        int         cyc;
        int         lat;
        logic       take;

        tbl[0] = mk(32'h100, 8'd3, 3'd2, 2'd1, 32'hA000_0040, 32'hA000_0041, 32'hA000_0042, 32'hA000_0043, OK, OK, OK, OK);
        tbl[1] = mk(32'h108, 8'd3, 3'd2, 2'd2, 32'hA000_0042, 32'hA000_0043, 32'hA000_0040, 32'hA000_0041, OK, OK, OK, OK);
        tbl[2] = mk(32'h020, 8'd3, 3'd2, 2'd0, 32'hA000_0008, 32'hA000_0008, 32'hA000_0008, 32'hA000_0008, OK, OK, OK, OK);
        tbl[3] = mk(32'h000, 8'd0, 3'd2, 2'd1, 32'hA000_0000, 32'h0, 32'h0, 32'h0, OK, OK, OK, OK);
        tbl[4] = mk(32'h3FFC, 8'd1, 3'd2, 2'd1, 32'hA000_0FFF, 32'h0, 32'h0, 32'h0, OK, SE, OK, OK);
        tbl[5] = mk(32'h000, 8'd2, 3'd2, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0, SE, SE, SE, OK);
        tbl[6] = mk(32'h100, 8'd2, 3'd2, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0, SE, SE, SE, OK);
        tbl[7] = mk(32'h000, 8'd1, 3'd3, 2'd1, 32'h0, 32'h0, 32'h0, 32'h0, SE, SE, OK, OK);
        tbl[8] = mk(32'h104, 8'd1, 3'd2, 2'd2, 32'hA000_0041, 32'hA000_0040, 32'h0, 32'h0, OK, OK, OK, OK);
        tbl[9] = mk(32'h100, 8'd3, 3'd0, 2'd1, 32'hA000_0040, 32'hA000_0040, 32'hA000_0040, 32'hA000_0040, OK, OK, OK, OK);

        rst_n        = 1'b0;
        bd_we        = 1'b0;
        bd_waddr     = '0;
        bd_wdata     = '0;
        axi0.araddr  = '0;
        axi0.arlen   = '0;
        axi0.arsize  = AXI_SIZE_4B;
        axi0.arburst = AXI_BURST_INCR;
        axi0.arvalid = 1'b0;
        axi0.rready  = 1'b1;
        axi1.araddr  = '0;
        axi1.arlen   = '0;
        axi1.arsize  = AXI_SIZE_4B;
        axi1.arburst = AXI_BURST_INCR;
        axi1.arvalid = 1'b0;
        axi1.rready  = 1'b1;

        // Preload both arrays through the backdoor while reset is held.
        @(negedge clk);
        bd_we = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            bd_waddr = 12'(k);
            bd_wdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
        end
        bd_we = 1'b0;

        check("rst_arready", 0, 32'(axi0.arready), 32'd1);
        check("rst_rvalid", 0, 32'(axi0.rvalid), 32'd0);
        check("rst_rlast", 0, 32'(axi0.rlast), 32'd0);
        check("rst_rresp", 0, 32'(axi0.rresp), 32'd0);
        check("rst_rdata", 0, axi0.rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_burst(i, tbl[i]);
        end

        // Backpressure: 8-beat INCR at 0x100 with a repeating rready pattern.
        pat = 7'b1101001;  // bit i is rready in stall-pattern slot i: 1,0,0,1,0,1,1
        axi0.rready  = 1'b0;
        axi0.araddr  = 32'h100;
        axi0.arlen   = 8'd7;
        axi0.arsize  = AXI_SIZE_4B;
        axi0.arburst = AXI_BURST_INCR;
        axi0.arvalid = 1'b1;
        @(posedge clk);
        #1;
        axi0.arvalid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!axi0.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 50, 32'(lat), 32'(LAT));
        hs  = 0;
        cyc = 0;
        while (hs < 8 && cyc < 40) begin
            check("bp_rvalid", 50 + cyc, 32'(axi0.rvalid), 32'd1);
            check("bp_rdata", 50 + cyc, axi0.rdata, 32'hA000_0040 + 32'(hs));
            check("bp_rlast", 50 + cyc, 32'(axi0.rlast), 32'(hs == 7));
            axi0.rready = pat[cyc % 7];
            take = axi0.rvalid && axi0.rready;
            @(negedge clk);
            if (take) hs++;
            cyc++;
        end
        check("bp_handshakes", 50, 32'(hs), 32'd8);
        check("bp_arready", 50, 32'(axi0.arready), 32'd1);
        check("bp_rvalid_end", 50, 32'(axi0.rvalid), 32'd0);
        axi0.rready = 1'b1;
        @(negedge clk);

        // Reset asserted while beat 2 of a 4-beat burst is on the bus.
        axi0.araddr  = 32'h0;
        axi0.arlen   = 8'd3;
        axi0.arsize  = AXI_SIZE_4B;
        axi0.arburst = AXI_BURST_INCR;
        axi0.arvalid = 1'b1;
        @(posedge clk);
        #1;
        axi0.arvalid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!axi0.rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        @(negedge clk);
        check("mid_rdata_beat2", 70, axi0.rdata, 32'hA000_0002);
        rst_n = 1'b0;
        #1;
        check("mid_rvalid", 70, 32'(axi0.rvalid), 32'd0);
        check("mid_rlast", 70, 32'(axi0.rlast), 32'd0);
        check("mid_arready", 70, 32'(axi0.arready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("mid_rvalid_hold", 71, 32'(axi0.rvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rvalid_after", 72, 32'(axi0.rvalid), 32'd0);
        do_burst(80, mk(32'h0, 8'd3, 3'd2, 2'd1, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, OK, OK, OK, OK));
        do_burst(81, tbl[0]);

        // Zero-latency build: rvalid in the cycle right after AR acceptance.
        check("l0_arready", 90, 32'(axi1.arready), 32'd1);
        axi1.araddr  = 32'h100;
        axi1.arlen   = 8'd1;
        axi1.arsize  = AXI_SIZE_4B;
        axi1.arburst = AXI_BURST_INCR;
        axi1.arvalid = 1'b1;
        @(posedge clk);
        #1;
        axi1.arvalid = 1'b0;
        check("l0_arready_busy", 90, 32'(axi1.arready), 32'd0);
        @(negedge clk);
        check("l0_rvalid0", 90, 32'(axi1.rvalid), 32'd1);
        check("l0_rdata0", 90, axi1.rdata, 32'hA000_0040);
        check("l0_rlast0", 90, 32'(axi1.rlast), 32'd0);
        @(negedge clk);
        check("l0_rvalid1", 91, 32'(axi1.rvalid), 32'd1);
        check("l0_rdata1", 91, axi1.rdata, 32'hA000_0041);
        check("l0_rlast1", 91, 32'(axi1.rlast), 32'd1);
        @(negedge clk);
        check("l0_rvalid_end", 92, 32'(axi1.rvalid), 32'd0);
        check("l0_arready_end", 92, 32'(axi1.arready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
